// File: rtl/activation_stream_reader.sv
// Read-side DMA: streams a (base, length) window of the activation buffer out as valid/ready
// words through a credit-guarded skid FIFO. Define ACT_READER_STRIDE_EN to add cmd_stride.
module activation_stream_reader #(
   parameter int unsigned ADDR_WIDTH   = 13,
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cmd_start,
   input  logic [ADDR_WIDTH-1:0] cmd_base,
   input  logic [ADDR_WIDTH:0]   cmd_length,
`ifdef ACT_READER_STRIDE_EN
   input  logic [ADDR_WIDTH-1:0] cmd_stride,
`endif
   output logic                  busy,
   output logic                  done,
   output logic                  buf_read_enable,
   output logic [ADDR_WIDTH-1:0] buf_read_addr,
   input  logic [DATA_WIDTH-1:0] buf_read_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned LenW = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LenW-1:0]       issued_q, issued_d;
   logic [LenW-1:0]       len_q, len_d;
   logic [CntW-1:0]       outst_q, outst_d;
   logic [CntW-1:0]       count_q, count_d;
   logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [READ_LATENCY-1:0] vld_q, lst_q;

   logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
   logic                  fifo_last_q [FIFO_DEPTH];

   logic                  accept, credit, issue, issue_last, push, pop, head_last;
   logic [ADDR_WIDTH-1:0] issue_addr, start_stride, run_stride;

   assign accept    = (state_q == StIdle) && cmd_start && !reset;
   assign credit    = outst_q < CntW'(FIFO_DEPTH);
   assign push      = vld_q[READ_LATENCY-1];
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;
   assign head_last = fifo_last_q[rd_ptr_q];
   assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
   assign out_last  = out_valid && head_last;

`ifdef ACT_READER_STRIDE_EN
   logic [ADDR_WIDTH-1:0] stride_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         stride_q <= '0;
      end else if (accept) begin
         stride_q <= cmd_stride;
      end
   end

   assign start_stride = cmd_stride;
   assign run_stride   = stride_q;
`else
   assign start_stride = ADDR_WIDTH'(1);
   assign run_stride   = ADDR_WIDTH'(1);
`endif

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // The first read goes out in the accepting cycle so data is streamable READ_LATENCY+1 later.
   always_comb begin
      issue      = 1'b0;
      issue_last = 1'b0;
      issue_addr = addr_q;
      addr_d     = addr_q;
      issued_d   = issued_q;
      len_d      = len_q;
      unique case (state_q)
         StIdle: begin
            if (accept && (cmd_length != '0)) begin
               issue      = 1'b1;
               issue_last = (cmd_length == LenW'(1));
               issue_addr = cmd_base;
               addr_d     = cmd_base + start_stride;
               issued_d   = LenW'(1);
               len_d      = cmd_length;
            end
         end
         StIssue: begin
            if (credit) begin
               issue      = 1'b1;
               issue_last = (issued_q + LenW'(1) == len_q);
               addr_d     = addr_q + run_stride;
               issued_d   = issued_q + LenW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (cmd_length == '0) begin
                  state_d = StDone;
               end else if (cmd_length == LenW'(1)) begin
                  state_d = StDrain;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: if (issue && issue_last) state_d = StDrain;
         StDrain: if (pop && head_last) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy            = (state_q == StIssue) || (state_q == StDrain);
      done            = (state_q == StDone);
      buf_read_enable = issue;
      buf_read_addr   = issue_addr;
   end

   // Credit counts reads in flight plus FIFO occupancy; it drops only when a word leaves.
   always_comb begin
      outst_d = outst_q + CntW'(issue) - CntW'(pop);
      count_d = count_q + CntW'(push) - CntW'(pop);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q   <= '0;
         issued_q <= '0;
         len_q    <= '0;
         outst_q  <= '0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         vld_q    <= '0;
         lst_q    <= '0;
      end else begin
         addr_q   <= addr_d;
         issued_q <= issued_d;
         len_q    <= len_d;
         outst_q  <= outst_d;
         count_q  <= count_d;
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         vld_q[0] <= issue;
         lst_q[0] <= issue && issue_last;
         for (int i = 1; i < int'(READ_LATENCY); i++) begin
            vld_q[i] <= vld_q[i-1];
            lst_q[i] <= lst_q[i-1];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_data_q[wr_ptr_q] <= buf_read_data;
         fifo_last_q[wr_ptr_q] <= lst_q[READ_LATENCY-1];
      end
   end

endmodule

// File: tb/tb_activation_stream_reader.sv
// Directed bench for activation_stream_reader with a 2-cycle-latency buffer model.
// Define ACT_READER_STRIDE_EN to also exercise the stride port.
module tb_activation_stream_reader;

   localparam int AW = 13;
   localparam int DW = 64;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_start = 1'b0;
   logic [AW-1:0] cmd_base = '0;
   logic [AW:0]   cmd_length = '0;
`ifdef ACT_READER_STRIDE_EN
   logic [AW-1:0] cmd_stride = AW'(1);
`endif
   logic          busy, done, buf_read_enable, out_valid, out_last;
   logic          out_ready = 1'b1;
   logic [AW-1:0] buf_read_addr;
   logic [DW-1:0] buf_read_data, out_data;

   activation_stream_reader dut (
      .clock           (clock),
      .reset           (reset),
      .cmd_start       (cmd_start),
      .cmd_base        (cmd_base),
      .cmd_length      (cmd_length),
`ifdef ACT_READER_STRIDE_EN
      .cmd_stride      (cmd_stride),
`endif
      .busy            (busy),
      .done            (done),
      .buf_read_enable (buf_read_enable),
      .buf_read_addr   (buf_read_addr),
      .buf_read_data   (buf_read_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_last        (out_last)
   );

   always #5 clock = ~clock;

   // Buffer model: word at address a holds a*3, data valid two cycles after the enable.
   logic [DW-1:0] mem [8192];
   logic [DW-1:0] rd1 = '0, rd2 = '0;
   initial for (int i = 0; i < 8192; i++) mem[i] = DW'(i * 3);
   always @(posedge clock) begin
      rd1 <= buf_read_enable ? mem[buf_read_addr] : '0;
      rd2 <= rd1;
   end
   assign buf_read_data = rd2;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic [DW-1:0] beat_data[$];
   bit            beat_last[$];
   int            beat_cyc[$];
   logic [AW-1:0] iss_addr[$];
   int            done_cyc[$];
   int            busy_cycles = 0, stall_viol = 0, outst = 0, max_outst = 0;
   bit            prev_stall = 0;
   logic [DW-1:0] prev_data = '0;
   bit            prev_last = 0;

   always @(negedge clock) begin
      if (reset) begin
         outst      = 0;
         prev_stall = 0;
      end else begin
         if (out_valid && out_ready) begin
            beat_data.push_back(out_data);
            beat_last.push_back(out_last);
            beat_cyc.push_back(cyc);
         end
         if (buf_read_enable) iss_addr.push_back(buf_read_addr);
         if (done) done_cyc.push_back(cyc);
         if (busy) busy_cycles++;
         if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
            stall_viol++;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         outst = outst + int'(buf_read_enable) - int'(out_valid && out_ready);
         if (outst > max_outst) max_outst = outst;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_log();
      beat_data.delete();
      beat_last.delete();
      beat_cyc.delete();
      iss_addr.delete();
      done_cyc.delete();
      busy_cycles = 0;
      stall_viol  = 0;
      max_outst   = 0;
   endtask

   task automatic start_cmd(input logic [AW-1:0] base, input logic [AW:0] len, output int c0);
      cmd_base   = base;
      cmd_length = len;
      cmd_start  = 1'b1;
      c0         = cyc;
      tick();
      cmd_start  = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget, input bit bp);
      logic [3:0] pat = 4'b1001;
      int k = 0;
      while (done_cyc.size() == 0 && k < budget) begin
         if (bp) out_ready = pat[k % 4];
         tick();
         k++;
      end
      out_ready = 1'b1;
      if (done_cyc.size() == 0) check({tag, "_timeout"}, 0, 1);
   endtask

   // Checks beats against a base/stride sequence of n words with last only on the final one.
   task automatic check_stream(input string tag, input int base, input int stride, input int n);
      check({tag, "_count"}, beat_data.size(), n);
      for (int i = 0; i < beat_data.size() && i < n; i++) begin
         check($sformatf("%s_data[%0d]", tag, i), beat_data[i], DW'(((base + i * stride) % 8192) * 3));
         check($sformatf("%s_last[%0d]", tag, i), beat_last[i], (i == n - 1));
      end
   endtask

   int c0;

   initial begin
      repeat (3) tick();
      reset = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_en", buf_read_enable, 0);
      check("rst_addr", buf_read_addr, 0);
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_data", out_data, 0);

      // Basic stream at full rate.
      clear_log();
      start_cmd(AW'('h100), 14'd8, c0);
      wait_done("basic", 100, 0);
      check_stream("basic", 'h100, 1, 8);
      for (int i = 0; i < beat_cyc.size(); i++)
         check($sformatf("basic_cyc[%0d]", i), beat_cyc[i] - c0, 3 + i);
      if (done_cyc.size() > 0) check("basic_done_cyc", done_cyc[0] - c0, 11);
      tick();
      check("basic_busy_after", busy, 0);
      check("basic_done_once", done_cyc.size(), 1);

      // Backpressure.
      clear_log();
      start_cmd(AW'('h200), 14'd16, c0);
      wait_done("bp", 300, 1);
      check_stream("bp", 'h200, 1, 16);
      check("bp_stable", stall_viol, 0);
      check("bp_outst_le4", (max_outst <= 4), 1);

      // Address wrap.
      clear_log();
      start_cmd(AW'('h1FFE), 14'd4, c0);
      wait_done("wrap", 100, 0);
      check("wrap_n_issue", iss_addr.size(), 4);
      for (int i = 0; i < iss_addr.size() && i < 4; i++)
         check($sformatf("wrap_addr[%0d]", i), iss_addr[i], (('h1FFE + i) % 8192));
      check_stream("wrap", 'h1FFE, 1, 4);

      // Zero length.
      tick();
      clear_log();
      start_cmd(AW'('h40), 14'd0, c0);
      wait_done("zero", 20, 0);
      if (done_cyc.size() > 0) check("zero_done_cyc", done_cyc[0] - c0, 1);
      check("zero_no_reads", iss_addr.size(), 0);
      check("zero_no_busy", busy_cycles, 0);

      // A start while busy is ignored.
      tick();
      clear_log();
      start_cmd(AW'('h300), 14'd8, c0);
      tick();
      cmd_base   = AW'('h000);
      cmd_length = 14'd3;
      cmd_start  = 1'b1;
      tick();
      cmd_start  = 1'b0;
      wait_done("ign", 100, 0);
      repeat (10) tick();
      check_stream("ign", 'h300, 1, 8);
      check("ign_n_issue", iss_addr.size(), 8);
      check("ign_done_once", done_cyc.size(), 1);

      // Reset in the cycle of the 5th beat of a 32-word command.
      clear_log();
      start_cmd(AW'('h400), 14'd32, c0);
      repeat (6) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mrst_valid", out_valid, 0);
      check("mrst_busy", busy, 0);
      check("mrst_data", out_data, 0);
      clear_log();
      repeat (20) tick();
      check("mrst_no_done", done_cyc.size(), 0);
      check("mrst_no_beats", beat_data.size(), 0);
      clear_log();
      start_cmd(AW'('h500), 14'd5, c0);
      wait_done("mrst_fresh", 100, 0);
      check_stream("mrst_fresh", 'h500, 1, 5);

`ifdef ACT_READER_STRIDE_EN
      tick();
      clear_log();
      cmd_stride = AW'(4);
      start_cmd(AW'('h10), 14'd3, c0);
      wait_done("stride", 100, 0);
      check("stride_n_issue", iss_addr.size(), 3);
      for (int i = 0; i < iss_addr.size() && i < 3; i++)
         check($sformatf("stride_addr[%0d]", i), iss_addr[i], 'h10 + 4 * i);
      check_stream("stride", 'h10, 4, 3);
      cmd_stride = AW'(1);
`endif

      tick();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
